// File: rtl/adder_pipe_nbit_if.sv
// Valid/ready stream bundle for the pipelined adder: operand beat in, result beat out.
// The producer/consumer side uses the master modport, the adder uses the slave modport.
interface adder_pipe_nbit_if #(
    parameter int N = 10
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   sum;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum
    );
endinterface

// File: rtl/adder_pipe_nbit.sv
// Pipelined N-bit add/subtract with valid/ready on both sides.
// The carry chain is cut into STAGES chunks of W = ceil(N/STAGES) bits; each stage
// adds one chunk and registers the low result bits so far, its carry-out and the
// operand bits still to be added. Subtraction is a + ~b + 1 (carry-in of chunk 0).
// A single global enable advances the whole pipe; on stall every stage holds.
module adder_pipe_nbit #(
    parameter int N      = 10,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    adder_pipe_nbit_if.slave   bus
);
    localparam int W = (STAGES < 1) ? 1 : (N + STAGES - 1) / STAGES;

    logic en_s;

    // Pipe advances when the output slot is empty or being drained this cycle.
    assign en_s        = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = en_s;

    if ((STAGES < 1) || ((STAGES - 1) * W >= N)) begin : g_bad_cfg
        $error("adder_pipe_nbit: STAGES=%0d leaves an empty chunk for N=%0d", STAGES, N);
    end else begin : g_pipe
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            localparam int LO = k * W;
            localparam int HI = ((k + 1) * W >= N) ? N - 1 : (k + 1) * W - 1;
            localparam int CW = HI - LO + 1;
            // Operand bits still outstanding when entering this stage: [N-1:LO].
            localparam int IN = N - LO;

            logic          vld_in_s;
            logic          sub_in_s;
            logic          cin_s;
            logic [IN-1:0] a_in_s;
            logic [IN-1:0] b_in_s;
            logic [CW-1:0] b_ck_s;
            logic [CW:0]   part_s;
            logic [HI:0]   res_d;
            logic [HI:0]   res_q;
            logic          vld_q;
            logic          cy_q;

            if (k == 0) begin : g_head
                assign vld_in_s = bus.in_valid;
                assign a_in_s   = bus.a;
                assign b_in_s   = bus.b;
                assign sub_in_s = bus.sub;
                assign cin_s    = bus.sub;
                assign res_d    = part_s[CW-1:0];
            end else begin : g_body
                assign vld_in_s = g_stage[k-1].vld_q;
                assign a_in_s   = g_stage[k-1].g_fwd.a_q;
                assign b_in_s   = g_stage[k-1].g_fwd.b_q;
                assign sub_in_s = g_stage[k-1].g_fwd.sub_q;
                assign cin_s    = g_stage[k-1].cy_q;
                assign res_d    = {part_s[CW-1:0], g_stage[k-1].res_q};
            end

            // Chunk adder: a chunk plus conditionally inverted b chunk plus incoming carry.
            always_comb begin
                b_ck_s = b_in_s[CW-1:0] ^ {CW{sub_in_s}};
                part_s = {1'b0, a_in_s[CW-1:0]} + {1'b0, b_ck_s} + {{CW{1'b0}}, cin_s};
            end

            // Stage register: valid, carry and accumulated result shift on enable, else hold.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= 1'b0;
                    cy_q  <= 1'b0;
                    res_q <= {(HI + 1){1'b0}};
                end else if (en_s) begin
                    vld_q <= vld_in_s;
                    cy_q  <= part_s[CW];
                    res_q <= res_d;
                end
            end

            if (k < STAGES - 1) begin : g_fwd
                logic [IN-CW-1:0] a_q;
                logic [IN-CW-1:0] b_q;
                logic             sub_q;

                // Carry the not-yet-added operand bits and op select to the next chunk.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_q   <= {(IN - CW){1'b0}};
                        b_q   <= {(IN - CW){1'b0}};
                        sub_q <= 1'b0;
                    end else if (en_s) begin
                        a_q   <= a_in_s[IN-1:CW];
                        b_q   <= b_in_s[IN-1:CW];
                        sub_q <= sub_in_s;
                    end
                end
            end
        end

        assign bus.out_valid = g_stage[STAGES-1].vld_q;
        assign bus.sum       = {g_stage[STAGES-1].cy_q, g_stage[STAGES-1].res_q};
    end
endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Self-checking bench for adder_pipe_nbit: four instances (STAGES = 2, 1, 3, 10, N = 10).
// Directed steps run on the STAGES=2 instance; the random phase drives all four at once
// against an arithmetic reference kept in per-instance expectation queues.
module tb_adder_pipe_nbit;
    localparam int N  = 10;
    localparam int ND = 4;
    localparam int ST_TAB [ND] = '{2, 1, 3, 10};

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic         in_valid_t  [ND];
    logic [N-1:0] a_t         [ND];
    logic [N-1:0] b_t         [ND];
    logic         sub_t       [ND];
    logic         out_ready_t [ND];
    wire          in_ready_w  [ND];
    wire          out_valid_w [ND];
    wire  [N:0]   sum_w       [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int ST = ST_TAB[g];
        adder_pipe_nbit_if #(.N(N)) bus ();
        assign bus.in_valid  = in_valid_t[g];
        assign bus.a         = a_t[g];
        assign bus.b         = b_t[g];
        assign bus.sub       = sub_t[g];
        assign bus.out_ready = out_ready_t[g];
        assign in_ready_w[g]  = bus.in_ready;
        assign out_valid_w[g] = bus.out_valid;
        assign sum_w[g]       = bus.sum;
        adder_pipe_nbit #(.N(N), .STAGES(ST)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic. For sub, a - b + 2^N puts the no-borrow flag in bit N.
    function automatic logic [N:0] ref_sum(input logic [N-1:0] av, input logic [N-1:0] bv,
                                           input logic sv);
        int d;
        if (sv) d = int'(av) - int'(bv) + (1 << N);
        else    d = int'(av) + int'(bv);
        return d[N:0];
    endfunction

    // One beat into an empty pipe with out_ready=1: checks in_ready, latency and result.
    task automatic lat_probe(input int g, input logic [N-1:0] av, input logic [N-1:0] bv,
                             input logic sv, input logic [N:0] exp, input string tag);
        int lat;
        in_valid_t[g]  = 1'b1;
        a_t[g]         = av;
        b_t[g]         = bv;
        sub_t[g]       = sv;
        out_ready_t[g] = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready_w[g], 1);
        @(posedge clk); #1;
        in_valid_t[g] = 1'b0;
        lat = 1;
        while (!out_valid_w[g] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, ST_TAB[g]);
        check({tag, "_sum"}, sum_w[g], exp);
        @(posedge clk); #1;
    endtask

    logic [N:0] exp_q [ND][$];
    logic [N:0] got_q [$];
    bit         hold       [ND];
    bit         stall_prev [ND];
    logic [N:0] sum_prev   [ND];
    int         sent       [ND];

    initial begin
        int         nxt;
        int         stall_left;
        int         stalled;
        int         cyc;
        bit         bp_prev;
        logic [N:0] bp_sum;
        bit         done;
        logic [N:0] e;

        rst_n = 1'b0;
        for (int g = 0; g < ND; g++) begin
            in_valid_t[g] = 1'b0; a_t[g] = '0; b_t[g] = '0; sub_t[g] = 1'b0;
            out_ready_t[g] = 1'b1;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < ND; g++) begin
            check("reset_out_valid", out_valid_w[g], 0);
            check("reset_sum", sum_w[g], 0);
            check("reset_in_ready", in_ready_w[g], 1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic add and chunk-boundary carries (W=5 on the STAGES=2 instance)
        lat_probe(0, 10'd1,    10'd99,   1'b0, 11'd100,  "add_1_99");
        lat_probe(0, 10'd31,   10'd1,    1'b0, 11'd32,   "add_31_1");
        lat_probe(0, 10'd1023, 10'd1,    1'b0, 11'd1024, "add_1023_1");
        lat_probe(0, 10'd1000, 10'd1000, 1'b0, 11'd2000, "add_1000_1000");

        // Subtract: no-borrow flag in sum[N]
        lat_probe(0, 10'd100, 10'd47,  1'b1, 11'd1077, "sub_100_47");
        lat_probe(0, 10'd47,  10'd100, 1'b1, 11'd971,  "sub_47_100");
        lat_probe(0, 10'd33,  10'd33,  1'b1, 11'd1024, "sub_33_33");

        // Backpressure: 5 back-to-back beats, out_ready low 3 cycles after first result
        got_q.delete();
        nxt = 1; stall_left = 0; stalled = 0; cyc = 0; bp_prev = 1'b0; bp_sum = '0;
        while (got_q.size() < 5 && cyc < 60) begin
            in_valid_t[0] = (nxt <= 5);
            a_t[0]        = N'(nxt);
            b_t[0]        = N'(10 * nxt);
            sub_t[0]      = 1'b0;
            if (stall_left > 0) begin
                out_ready_t[0] = 1'b0;
                stall_left--;
                stalled++;
            end else begin
                out_ready_t[0] = 1'b1;
            end
            @(negedge clk);
            if (bp_prev) begin
                check("bp_hold_valid", out_valid_w[0], 1);
                check("bp_hold_sum", sum_w[0], bp_sum);
            end
            if (out_valid_w[0] && !out_ready_t[0]) check("bp_in_ready_low", in_ready_w[0], 0);
            if (in_valid_t[0] && in_ready_w[0]) nxt++;
            if (out_valid_w[0] && out_ready_t[0]) begin
                got_q.push_back(sum_w[0]);
                if (got_q.size() == 1) stall_left = 3;
            end
            bp_prev = out_valid_w[0] && !out_ready_t[0];
            bp_sum  = sum_w[0];
            @(posedge clk); #1;
            cyc++;
        end
        in_valid_t[0] = 1'b0; out_ready_t[0] = 1'b1;
        check("bp_count", got_q.size(), 5);
        check("bp_stalled_cycles", stalled, 3);
        for (int i = 0; i < got_q.size(); i++) check("bp_order", got_q[i], 11 * (i + 1));

        // Reset mid-flight: two beats in the pipe, asynchronous pulse between edges
        in_valid_t[0] = 1'b1; a_t[0] = 10'd5; b_t[0] = 10'd6; sub_t[0] = 1'b0;
        @(posedge clk); #1;
        a_t[0] = 10'd7; b_t[0] = 10'd8;
        @(posedge clk); #1;
        in_valid_t[0] = 1'b0;
        check("pre_reset_valid", out_valid_w[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid_w[0], 0);
        check("rst_sum", sum_w[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("rst_no_stale", out_valid_w[0], 0);
        end
        lat_probe(0, 10'd33, 10'd66, 1'b0, 11'd99, "post_reset");

        // Latency per depth on the other instances
        for (int g = 1; g < ND; g++) begin
            lat_probe(g, 10'd1023, 10'd1, 1'b0, 11'd1024, "depth_add");
            lat_probe(g, 10'd47, 10'd100, 1'b1, 11'd971, "depth_sub");
        end

        // Random sweep: 1000 beats per instance, random valid and out_ready
        for (int g = 0; g < ND; g++) begin
            exp_q[g].delete(); hold[g] = 1'b0; stall_prev[g] = 1'b0; sent[g] = 0;
        end
        done = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            for (int g = 0; g < ND; g++) begin
                if (!hold[g]) begin
                    in_valid_t[g] = (sent[g] < 1000) && ($urandom_range(0, 3) != 0);
                    a_t[g]        = N'($urandom);
                    b_t[g]        = N'($urandom);
                    sub_t[g]      = 1'($urandom_range(0, 1));
                end
                out_ready_t[g] = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            for (int g = 0; g < ND; g++) begin
                check("rnd_in_ready", in_ready_w[g], out_ready_t[g] || !out_valid_w[g]);
                if (stall_prev[g]) begin
                    check("rnd_hold_valid", out_valid_w[g], 1);
                    check("rnd_hold_sum", sum_w[g], sum_prev[g]);
                end
                if (out_valid_w[g] && out_ready_t[g]) begin
                    if (exp_q[g].size() == 0) begin
                        check("rnd_spurious_beat", 1, 0);
                    end else begin
                        e = exp_q[g].pop_front();
                        check("rnd_sum", sum_w[g], e);
                    end
                end
                if (in_valid_t[g] && in_ready_w[g]) begin
                    exp_q[g].push_back(ref_sum(a_t[g], b_t[g], sub_t[g]));
                    sent[g]++;
                end
                hold[g]       = in_valid_t[g] && !in_ready_w[g];
                stall_prev[g] = out_valid_w[g] && !out_ready_t[g];
                sum_prev[g]   = sum_w[g];
            end
            @(posedge clk); #1;
            done = 1'b1;
            for (int g = 0; g < ND; g++)
                if (sent[g] < 1000 || exp_q[g].size() != 0 || hold[g]) done = 1'b0;
        end
        check("rnd_completed", done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adder_pipe_nbit.md
Name: adder_pipe_nbit

Overview:
Pipelined, parameterised N-bit add/subtract unit with a valid/ready handshake on both sides. It is the registered successor to the team's combinational N-bit adder. The carry chain is split into STAGES chunks, with one register stage per chunk, so wide operands close timing. It sits between any producer and consumer that use valid/ready streaming and accepts one operation per clock.

Parameters:
N, 10, operand width in bits; result is N+1 bits.
STAGES, 2, pipeline depth and number of carry-chain chunks (1..N).
- Chunk width W = ceil(N/STAGES). Chunk k covers bits [min(N,(k+1)W)-1 : kW]. The last chunk takes the remainder.
- Legal only if (STAGES-1)*W < N. Otherwise elaboration fails via a generate-time error.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat present
in_ready  output  1  unit accepts a beat this cycle
a  input  N  operand A (unsigned)
b  input  N  operand B (unsigned)
sub  input  1  0: a+b, 1: a-b
out_valid  output  1  result beat present
out_ready  input  1  consumer accepts result this cycle
sum  output  N+1  result; sum[N] = carry-out

Behaviour:
- Reset: asynchronous assert on rst_n low. All stage valid bits clear immediately, so out_valid=0. Data registers and sum go to 0. Deassertion is synchronous to clk and is handled externally.
- Arithmetic:
  - add: sum = a + b, zero-extended to N+1 bits.
  - sub: computed as a + ~b + 1. sum[N-1:0] = (a-b) mod 2^N. sum[N] = 1 when a >= b (no borrow), 0 when a < b.
- Pipeline structure:
  - Stage k (k = 0..STAGES-1) adds chunk k of a and the (conditionally inverted) b, plus the carry registered from stage k-1. Stage 0 uses carry-in = sub.
  - Each stage registers its partial result bits, its carry-out, and the not-yet-added upper chunks of a, b, and sub.
  - The final stage drives sum[N-1:0]; its registered carry-out drives sum[N].
- Latency: exactly STAGES cycles from the accept edge (in_valid & in_ready) to out_valid, assuming no stall. STAGES=1 gives a single output register.
- Handshake:
  - Global enable: en = out_ready | ~out_valid. in_ready = en, combinational from out_ready and the last-stage valid.
  - When en=1, every stage shifts one position. Stage 0 loads valid = in_valid, plus data.
  - When en=0, every stage holds, including interior bubbles. Bubbles are not collapsed except at the output.
  - A beat transfers out on out_valid & out_ready. Producer beats are accepted on in_valid & in_ready.
- Protocol rules:
  - Throughput is 1 beat/cycle under continuous out_ready=1.
  - No beat is dropped, duplicated, or reordered.
  - sum and out_valid stay stable while out_valid=1 & out_ready=0.
  - a, b, and sub are sampled only on the accept edge. Values with in_valid=0 never produce out_valid.
- Simultaneous events: when the output is popped and the input is accepted in the same cycle, both happen and occupancy is unchanged. in_valid=1 with in_ready=0 has no effect, and the producer must hold its beat.
- Reset mid-operation: all in-flight beats are discarded. After release, the first accepted beat appears after STAGES cycles.
- Wrap-around: there is no saturation. Overflow shows only in sum[N] for add, or sum[N]=0 for sub.

Test Plan:
1. N=10, STAGES=2, out_ready=1: a=1, b=99, sub=0 -> out_valid exactly 2 cycles after accept, sum=100, sum[10]=0.
2. Chunk-boundary carry (W=5): a=31, b=1 -> sum=32. Then a=1023, b=1 -> sum=1024 (sum[10]=1). Then a=1000, b=1000 -> sum=2000.
3. Subtract: a=100, b=47, sub=1 -> sum[9:0]=53, sum[10]=1. Then a=47, b=100, sub=1 -> sum[9:0]=971, sum[10]=0. Then a=b=33, sub=1 -> sum[9:0]=0, sum[10]=1.
4. Backpressure: stream 5 back-to-back beats (a=i, b=10*i, i=1..5). Drop out_ready for 3 cycles after the first result -> in_ready=0 during the stall, sum held stable. Outputs are 11, 22, 33, 44, 55, in order, with none lost.
5. Reset mid-flight: accept 2 beats, pulse rst_n low between clock edges -> out_valid=0 immediately, no stale result ever appears. A post-reset beat 33+66 gives sum=99 after 2 cycles.
6. Sweep STAGES=1, 3, 10 with N=10 against a reference model over 1000 random beats with random out_ready -> zero mismatches; latency equals STAGES.
